// File: rtl/rw_control_logic.sv
// 8254 bus-side control: decodes control words and count writes per counter,
// assembles initial counts with a newCount pulse, and serves latched/live reads.

module rw_cnt_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_wr,
    input  logic        latch_cmd,
    input  logic        data_wr,
    input  logic        data_rd,
    input  logic [7:0]  data_in,
    input  logic [15:0] cur_count,
    output logic [15:0] count,
    output logic        new_count,
    output logic [2:0]  mode,
    output logic        bcd,
    output logic [7:0]  rd_byte
);
    logic [1:0]  rw_fmt;
    logic        wtog, rtog, latch_valid;
    logic [15:0] latch, src;
    logic [7:0]  lsb_stage;

    assign src = latch_valid ? latch : cur_count;

    always_comb begin
        rd_byte = 8'h00;
        case (rw_fmt)
            2'b01:   rd_byte = src[7:0];
            2'b10:   rd_byte = src[15:8];
            2'b11:   rd_byte = rtog ? src[15:8] : src[7:0];
            default: rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rw_fmt      <= 2'b00;
            mode        <= 3'd0;
            bcd         <= 1'b0;
            wtog        <= 1'b0;
            rtog        <= 1'b0;
            latch_valid <= 1'b0;
            latch       <= 16'h0000;
            lsb_stage   <= 8'h00;
            count       <= 16'h0000;
            new_count   <= 1'b0;
        end else begin
            new_count <= 1'b0;
            if (ctrl_wr) begin
                rw_fmt      <= data_in[5:4];
                // modes 6/7 alias to 2/3
                mode        <= {data_in[3] & ~data_in[2], data_in[2:1]};
                bcd         <= data_in[0];
                wtog        <= 1'b0;
                rtog        <= 1'b0;
                latch_valid <= 1'b0;
            end
            if (latch_cmd && !latch_valid) begin
                latch       <= cur_count;
                latch_valid <= 1'b1;
            end
            if (data_wr) begin
                case (rw_fmt)
                    2'b01: begin
                        count     <= {8'h00, data_in};
                        new_count <= 1'b1;
                    end
                    2'b10: begin
                        count     <= {data_in, 8'h00};
                        new_count <= 1'b1;
                    end
                    2'b11: begin
                        if (!wtog) begin
                            lsb_stage <= data_in;
                            wtog      <= 1'b1;
                        end else begin
                            count     <= {data_in, lsb_stage};
                            wtog      <= 1'b0;
                            new_count <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (data_rd) begin
                if (rw_fmt == 2'b11)
                    rtog <= ~rtog;
                if (rw_fmt == 2'b01 || rw_fmt == 2'b10 || (rw_fmt == 2'b11 && rtog))
                    latch_valid <= 1'b0;
            end
        end
    end
endmodule

module rw_control_logic #(
    parameter int NUM_CNT = 3,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cs,
    input  logic                     wr,
    input  logic                     rd,
    input  logic [1:0]               addr,
    input  logic [7:0]               data_in,
    input  logic [NUM_CNT*CNT_W-1:0] cur_count,
    output logic [7:0]               data_out,
    output logic [NUM_CNT*CNT_W-1:0] count,
    output logic [NUM_CNT-1:0]       newCount,
    output logic [NUM_CNT*3-1:0]     mode,
    output logic [NUM_CNT-1:0]       bcd
);
    logic                               wr_en, rd_en, ctrl;
    logic [NUM_CNT-1:0][CNT_W-1:0]      cnt_arr;
    logic [NUM_CNT-1:0][2:0]            mode_arr;
    logic [NUM_CNT-1:0][7:0]            rd_byte;
    logic [7:0]                         rd_sel;

    // write has priority; a simultaneous read is dropped
    assign wr_en = cs & wr;
    assign rd_en = cs & rd & ~wr;
    assign ctrl  = wr_en && (addr == 2'b11);

    genvar i;
    generate
        for (i = 0; i < NUM_CNT; i++) begin : g_cnt
            logic sel_ctrl;
            assign sel_ctrl = ctrl && (data_in[7:6] == 2'(i));
            rw_cnt_slot u_slot (
                .clk       (clk),
                .rst       (rst),
                .ctrl_wr   (sel_ctrl && (data_in[5:4] != 2'b00)),
                .latch_cmd (sel_ctrl && (data_in[5:4] == 2'b00)),
                .data_wr   (wr_en && (addr == 2'(i))),
                .data_rd   (rd_en && (addr == 2'(i))),
                .data_in   (data_in),
                .cur_count (cur_count[CNT_W*i +: CNT_W]),
                .count     (cnt_arr[i]),
                .new_count (newCount[i]),
                .mode      (mode_arr[i]),
                .bcd       (bcd[i]),
                .rd_byte   (rd_byte[i])
            );
        end
    endgenerate

    assign count = cnt_arr;
    assign mode  = mode_arr;

    // absent counters and the control address read as zero
    always_comb begin
        rd_sel = 8'h00;
        for (int k = 0; k < NUM_CNT; k++)
            if (addr == 2'(k))
                rd_sel = rd_byte[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            data_out <= 8'h00;
        else if (rd_en)
            data_out <= rd_sel;
    end
endmodule

// File: tb/tb_rw_control_logic.sv
// Directed bench for rw_control_logic: expected counts and read bytes are queued
// when a bus cycle is driven and popped for comparison once the edge has passed.

module tb_rw_control_logic;
    logic        clk = 0, rst = 1, cs = 0, wr = 0, rd = 0;
    logic [1:0]  addr = 0;
    logic [7:0]  data_in = 0;
    logic [47:0] cur_count = 0;
    logic [7:0]  data_out;
    logic [47:0] count;
    logic [2:0]  newCount;
    logic [8:0]  mode;
    logic [2:0]  bcd;

    typedef struct { string tag; logic [15:0] val; } exp_t;
    exp_t sbq[$];
    int vectors = 0, fails = 0;

    rw_control_logic dut (
        .clk(clk), .rst(rst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
        .data_in(data_in), .cur_count(cur_count), .data_out(data_out),
        .count(count), .newCount(newCount), .mode(mode), .bcd(bcd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic c, input logic w, input logic r,
                       input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        cs = c; wr = w; rd = r; addr = a; data_in = d;
        @(posedge clk);
        #1;
        cs = 0; wr = 0; rd = 0;
    endtask

    task automatic ctrl_wr(input logic [7:0] d);
        bus(1, 1, 0, 2'b11, d);
    endtask

    task automatic wr_cnt(input int i, input logic [7:0] d, input bit load,
                          input logic [15:0] exp_cnt, input string tag);
        exp_t e;
        sbq.push_back('{tag, exp_cnt});
        bus(1, 1, 0, 2'(i), d);
        e = sbq.pop_front();
        chk(e.tag, count[16*i +: 16], e.val);
        chk({tag, "_pulse"}, newCount, load ? (48'd1 << i) : 48'd0);
    endtask

    task automatic rd_cnt(input logic [1:0] a, input logic [7:0] exp, input string tag);
        exp_t e;
        sbq.push_back('{tag, {8'h00, exp}});
        bus(1, 0, 1, a, 8'h00);
        e = sbq.pop_front();
        chk(e.tag, data_out, e.val);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 48'h0);
        chk("rst_pulse", newCount, 0);
        chk("rst_mode", mode, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_dout", data_out, 0);
        @(negedge clk); rst = 0;

        rd_cnt(0, 8'h00, "rd_unprog");

        ctrl_wr(8'h32);
        chk("mode0_1", mode[2:0], 3'd1);
        wr_cnt(0, 8'h34, 0, 16'h0000, "c0_lsb");
        wr_cnt(0, 8'h12, 1, 16'h1234, "c0_msb");
        bus(0, 0, 0, 2'b00, 8'h00);
        chk("pulse_end", newCount, 0);

        ctrl_wr(8'h52);
        wr_cnt(1, 8'hA5, 1, 16'h00A5, "c1_lsb_only");
        ctrl_wr(8'h62);
        wr_cnt(1, 8'h07, 1, 16'h0700, "c1_msb_only");
        wr_cnt(1, 8'h08, 1, 16'h0800, "b2b_a");
        wr_cnt(1, 8'h09, 1, 16'h0900, "b2b_b");
        chk("c0_kept", count[15:0], 16'h1234);

        ctrl_wr(8'h3F);
        chk("mode0_7to3", mode[2:0], 3'd3);
        chk("bcd0", bcd, 3'b001);
        chk("ctrl_keeps_count", count[15:0], 16'h1234);
        ctrl_wr(8'hC0);
        chk("readback_mode", mode, {3'd0, 3'd1, 3'd3});
        chk("readback_count", count, {16'h0000, 16'h0900, 16'h1234});
        chk("readback_dout", data_out, 8'h00);

        cur_count = {16'h0000, 16'hABCD, 16'hBEEF};
        ctrl_wr(8'h00);
        cur_count[15:0] = 16'h1111;
        ctrl_wr(8'h00);
        rd_cnt(0, 8'hEF, "latch_lsb");
        rd_cnt(0, 8'hBE, "latch_msb");
        rd_cnt(0, 8'h11, "live_lsb");
        rd_cnt(0, 8'h11, "live_msb");
        rd_cnt(1, 8'hAB, "c1_fmt10_rd");
        rd_cnt(2'b11, 8'h00, "rd_ctrl_addr");

        wr_cnt(0, 8'h44, 0, 16'h1234, "il_lsb");
        rd_cnt(0, 8'h11, "il_read");
        wr_cnt(0, 8'h22, 1, 16'h2244, "il_msb");

        wr_cnt(0, 8'h34, 0, 16'h2244, "pre_rst_lsb");
        @(negedge clk); rst = 1;
        #1;
        chk("async_rst_count", count, 48'h0);
        chk("async_rst_mode", mode, 0);
        chk("async_rst_dout", data_out, 0);
        @(negedge clk); rst = 0;
        ctrl_wr(8'h32);
        wr_cnt(0, 8'h56, 0, 16'h0000, "post_rst_lsb");
        wr_cnt(0, 8'h78, 1, 16'h7856, "post_rst_msb");

        rd_cnt(0, 8'h11, "pre_cs_rd");
        cur_count[15:0] = 16'h5A5A;
        bus(0, 1, 0, 2'b00, 8'h99);
        chk("cs0_wr_count", count[15:0], 16'h7856);
        chk("cs0_wr_pulse", newCount, 0);
        bus(0, 0, 1, 2'b00, 8'h00);
        chk("cs0_rd_dout", data_out, 8'h11);
        bus(1, 1, 1, 2'b00, 8'hAA);
        chk("wrrd_dout", data_out, 8'h11);
        chk("wrrd_pulse", newCount, 0);
        wr_cnt(0, 8'hBB, 1, 16'hBBAA, "wrrd_msb");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
